// File: rtl/qpu_dtcm_ctrl_if.sv
// rtl/qpu_dtcm_ctrl_if.sv - one DTCM command/response channel (load/store unit or loader/debug)
interface qpu_dtcm_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = DW / 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/qpu_dtcm_ctrl.sv
// rtl/qpu_dtcm_ctrl.sv - two-channel round-robin front-end for the single-port DTCM SRAM
module qpu_dtcm_ctrl #(
  parameter int RAM_AW  = 14,
  parameter int DW      = 32,
  parameter int MW      = DW / 8,
  parameter int LS_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  qpu_dtcm_ctrl_if.slave    a,
  qpu_dtcm_ctrl_if.slave    b,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_ls
);

  localparam int BW = $clog2(MW);
  localparam int AW = RAM_AW + BW;
  localparam int CW = (LS_IDLE > 0) ? $clog2(LS_IDLE + 1) : 1;
  localparam logic [CW-1:0] LS_MAX = CW'(LS_IDLE);

  typedef enum logic {LS_AWAKE = 1'b0, LS_ASLEEP = 1'b1} ls_state_e;

  ls_state_e     ls_q, ls_d;
  logic [CW-1:0] idle_cnt;
  logic          prio_b;
  logic          rsp_pend, rsp_ch_b, rsp_is_rd, rsp_err_q, rsp_fresh;
  logic [DW-1:0] rsp_hold;

  logic          rsp_hs, accept, gnt_a, gnt_b, gnt, g_read, g_mis, wake, idle;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, rsp_data;
  logic [MW-1:0] g_wmask;

  assign ram_ls = (ls_q == LS_ASLEEP);

  always_comb begin
    // Data arrives straight from the RAM only in the first response cycle; afterwards from the hold register.
    rsp_data = rsp_fresh ? (rsp_is_rd ? ram_dout : '0) : rsp_hold;
    rsp_hs   = rsp_pend && (rsp_ch_b ? b.rsp_ready : a.rsp_ready);
    accept   = rst_n && (ls_q == LS_AWAKE) && (!rsp_pend || rsp_hs);
    gnt_a    = accept && a.cmd_valid && (!b.cmd_valid || !prio_b);
    gnt_b    = accept && b.cmd_valid && (!a.cmd_valid || prio_b);
    gnt      = gnt_a || gnt_b;

    g_read   = gnt_b ? b.cmd_read  : a.cmd_read;
    g_addr   = gnt_b ? b.cmd_addr  : a.cmd_addr;
    g_wdata  = gnt_b ? b.cmd_wdata : a.cmd_wdata;
    g_wmask  = gnt_b ? b.cmd_wmask : a.cmd_wmask;
    g_mis    = |g_addr[BW-1:0];

    ram_cs   = gnt && !g_mis;
    ram_we   = ram_cs && !g_read;
    ram_addr = ram_cs ? g_addr[AW-1:BW] : '0;
    ram_wem  = ram_cs ? g_wmask : '0;
    ram_din  = ram_cs ? g_wdata : '0;

    a.cmd_ready = gnt_a;
    b.cmd_ready = gnt_b;
    a.rsp_valid = rsp_pend && !rsp_ch_b;
    b.rsp_valid = rsp_pend && rsp_ch_b;
    a.rsp_rdata = a.rsp_valid ? rsp_data : '0;
    b.rsp_rdata = b.rsp_valid ? rsp_data : '0;
    a.rsp_err   = a.rsp_valid && rsp_err_q;
    b.rsp_err   = b.rsp_valid && rsp_err_q;

    wake = ram_ls && (a.cmd_valid || b.cmd_valid);
    idle = !ram_cs && !rsp_pend;
  end

  always_comb begin
    ls_d = ls_q;
    case (ls_q)
      LS_AWAKE:  if ((LS_IDLE != 0) && !gnt && idle && (idle_cnt == LS_MAX)) ls_d = LS_ASLEEP;
      LS_ASLEEP: if (wake) ls_d = LS_AWAKE;
      default:   ls_d = LS_AWAKE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_q     <= LS_AWAKE;
      idle_cnt <= '0;
    end else begin
      ls_q <= ls_d;
      if (gnt || wake) begin
        idle_cnt <= '0;
      end else if (idle && (idle_cnt != LS_MAX)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b    <= 1'b0;
      rsp_pend  <= 1'b0;
      rsp_ch_b  <= 1'b0;
      rsp_is_rd <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_fresh <= 1'b0;
      rsp_hold  <= '0;
    end else begin
      if (gnt) begin
        prio_b    <= gnt_a;
        rsp_pend  <= 1'b1;
        rsp_ch_b  <= gnt_b;
        rsp_is_rd <= g_read && !g_mis;
        rsp_err_q <= g_mis;
        rsp_fresh <= 1'b1;
      end else begin
        if (rsp_hs) rsp_pend <= 1'b0;
        // Stalled response: freeze the RAM output before it becomes invalid.
        if (rsp_pend && rsp_fresh) begin
          rsp_hold  <= rsp_data;
          rsp_fresh <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpu_dtcm_ctrl.sv
// tb/tb_qpu_dtcm_ctrl.sv - self-checking bench for qpu_dtcm_ctrl with a transaction-level reference model
module tb_qpu_dtcm_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qpu_dtcm_ctrl_if #(.AW(16), .DW(32), .MW(4)) a_if ();
  qpu_dtcm_ctrl_if #(.AW(16), .DW(32), .MW(4)) b_if ();

  logic        ram_cs, ram_we, ram_ls;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  qpu_dtcm_ctrl #(.RAM_AW(14), .DW(32), .MW(4), .LS_IDLE(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_if),
    .b        (b_if),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_ls   (ram_ls)
  );

  // SRAM with 1-cycle read latency; output is garbage on cycles after non-reads.
  logic [31:0] ram_mem [0:16383];
  always @(posedge clk) begin
    if (ram_cs && ram_we)
      for (int j = 0; j < 4; j++)
        if (ram_wem[j]) ram_mem[ram_addr][8*j +: 8] <= ram_din[8*j +: 8];
    if (ram_cs && !ram_we) ram_dout <= ram_mem[ram_addr];
    else                   ram_dout <= $urandom;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: responses computed from a word-level memory image at grant time.
  logic [31:0] mdl_mem [int];
  bit          m_pend, m_ch_b, m_err, m_ls, m_last_b;
  int          m_idle;
  logic [31:0] m_rdata;
  bit          hs, acc, ga, gb, mis, pend_old;
  logic        c_read;
  logic [15:0] c_addr;
  logic [31:0] c_wdata, cur;
  logic [3:0]  c_wmask;
  logic [51:0] exp_ram;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_ls = 0; m_idle = 0; m_last_b = 1; m_err = 0; m_rdata = '0; m_ch_b = 0;
      chk("m_rst_ram", {ram_cs, ram_we, ram_addr, ram_wem, ram_din}, 0);
      chk("m_rst_rsp", {a_if.rsp_valid, b_if.rsp_valid, a_if.rsp_err, b_if.rsp_err, a_if.rsp_rdata, b_if.rsp_rdata}, 0);
      chk("m_rst_ls", ram_ls, 0);
    end else begin
      hs  = m_pend && (m_ch_b ? b_if.rsp_ready : a_if.rsp_ready);
      acc = !m_ls && (!m_pend || hs);
      ga  = acc && a_if.cmd_valid && (!b_if.cmd_valid || m_last_b);
      gb  = acc && b_if.cmd_valid && (!a_if.cmd_valid || !m_last_b);
      c_read  = gb ? b_if.cmd_read  : a_if.cmd_read;
      c_addr  = gb ? b_if.cmd_addr  : a_if.cmd_addr;
      c_wdata = gb ? b_if.cmd_wdata : a_if.cmd_wdata;
      c_wmask = gb ? b_if.cmd_wmask : a_if.cmd_wmask;
      mis = (c_addr % 4) != 0;
      exp_ram = ((ga || gb) && !mis) ? {1'b1, !c_read, c_addr[15:2], c_wmask, c_wdata} : '0;

      chk("m_ram", {ram_cs, ram_we, ram_addr, ram_wem, ram_din}, exp_ram);
      chk("m_ready", {a_if.cmd_ready, b_if.cmd_ready}, {ga, gb});
      chk("m_ls", ram_ls, m_ls);
      chk("m_a_rsp", {a_if.rsp_valid, a_if.rsp_err, a_if.rsp_rdata},
          (m_pend && !m_ch_b) ? {1'b1, m_err, m_rdata} : 34'h0);
      chk("m_b_rsp", {b_if.rsp_valid, b_if.rsp_err, b_if.rsp_rdata},
          (m_pend && m_ch_b) ? {1'b1, m_err, m_rdata} : 34'h0);

      pend_old = m_pend;
      if (ga || gb) begin
        m_pend = 1; m_ch_b = gb; m_last_b = gb; m_idle = 0; m_err = mis; m_rdata = '0;
        if (!mis) begin
          if (c_read) begin
            m_rdata = mdl_mem[int'(c_addr[15:2])];
          end else begin
            cur = mdl_mem.exists(int'(c_addr[15:2])) ? mdl_mem[int'(c_addr[15:2])] : 32'h0;
            for (int j = 0; j < 4; j++)
              if (c_wmask[j]) cur[8*j +: 8] = c_wdata[8*j +: 8];
            mdl_mem[int'(c_addr[15:2])] = cur;
          end
        end
      end else if (hs) begin
        m_pend = 0;
      end
      if (m_ls) begin
        if (a_if.cmd_valid || b_if.cmd_valid) begin m_ls = 0; m_idle = 0; end
      end else if (!(ga || gb) && !pend_old) begin
        if (m_idle == 16) m_ls = 1;
        else              m_idle++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic rd, input logic [15:0] ad, input logic [31:0] wd, input logic [3:0] wm);
    a_if.cmd_valid = v; a_if.cmd_read = rd; a_if.cmd_addr = ad; a_if.cmd_wdata = wd; a_if.cmd_wmask = wm;
  endtask

  task automatic drive_b(input logic v, input logic rd, input logic [15:0] ad, input logic [31:0] wd, input logic [3:0] wm);
    b_if.cmd_valid = v; b_if.cmd_read = rd; b_if.cmd_addr = ad; b_if.cmd_wdata = wd; b_if.cmd_wmask = wm;
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    a_if.rsp_ready = 1'b1;
    b_if.rsp_ready = 1'b1;
    tick(); tick();
    #2;
    chk("rst_cs", ram_cs, 0);
    chk("rst_a_valid", a_if.rsp_valid, 0);
    chk("rst_ls", ram_ls, 0);
    chk("rst_b_rdata", b_if.rsp_rdata, 0);
    tick();
    rst_n = 1'b1;

    // Write then read through A
    tick();
    drive_a(1, 0, 16'h0010, 32'hDEADBEEF, 4'hF);
    #2;
    chk("t1_wr_ram", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b1, 14'h004});
    chk("t1_wr_rdy", a_if.cmd_ready, 1);
    tick();
    drive_a(1, 1, 16'h0010, 32'h0, 4'h0);
    #2;
    chk("t1_rd_ram", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b0, 14'h004});
    chk("t1_wr_rsp", {a_if.rsp_valid, a_if.rsp_rdata}, {1'b1, 32'h0});
    tick();
    drive_a(0, 0, 0, 0, 0);
    #2;
    chk("t1_rd_rsp", {a_if.rsp_valid, a_if.rsp_err, a_if.rsp_rdata}, {2'b10, 32'hDEADBEEF});
    chk("t1_b_quiet", b_if.rsp_valid, 0);

    // Partial write
    tick();
    drive_a(1, 0, 16'h0010, 32'h11223344, 4'h3);
    tick();
    drive_a(1, 1, 16'h0010, 32'h0, 4'h0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    #2;
    chk("t2_rdata", a_if.rsp_rdata, 32'hDEAD3344);

    // Contention after a B write
    tick();
    drive_b(1, 0, 16'h0020, 32'h0BADCAFE, 4'hF);
    tick();
    drive_a(1, 1, 16'h0010, 32'h0, 4'h0);
    drive_b(1, 1, 16'h0020, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("t3_gnt", {a_if.cmd_ready, b_if.cmd_ready, ram_cs}, (i % 2 == 0) ? 3'b101 : 3'b011);
      if (i > 0)
        chk("t3_rsp", {a_if.rsp_valid, b_if.rsp_valid, a_if.rsp_rdata | b_if.rsp_rdata},
            (i % 2 == 1) ? {2'b10, 32'hDEAD3344} : {2'b01, 32'h0BADCAFE});
      tick();
    end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);

    // Back-pressure on a read response
    tick();
    drive_a(1, 0, 16'h0030, 32'hCAFEF00D, 4'hF);
    tick();
    drive_a(1, 1, 16'h0030, 32'h0, 4'h0);
    tick();
    a_if.rsp_ready = 1'b0;
    drive_a(1, 1, 16'h0010, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t4_hold", {a_if.rsp_valid, a_if.rsp_rdata}, {1'b1, 32'hCAFEF00D});
      chk("t4_stall", {a_if.cmd_ready, ram_cs}, 2'b00);
      tick();
    end
    a_if.rsp_ready = 1'b1;
    #2;
    chk("t4_resume", {a_if.rsp_valid, a_if.rsp_rdata, a_if.cmd_ready, ram_cs}, {1'b1, 32'hCAFEF00D, 2'b11});
    tick();
    drive_a(0, 0, 0, 0, 0);
    #2;
    chk("t4_next", a_if.rsp_rdata, 32'hDEAD3344);

    // Misaligned read
    tick();
    drive_a(1, 1, 16'h0013, 32'h0, 4'h0);
    #2;
    chk("t5_cs", {a_if.cmd_ready, ram_cs}, 2'b10);
    tick();
    drive_a(0, 0, 0, 0, 0);
    #2;
    chk("t5_err", {a_if.rsp_valid, a_if.rsp_err, a_if.rsp_rdata}, {2'b11, 32'h0});

    // Light sleep, wake, then reset mid-response
    tick();
    n = 0;
    while (n < 40) begin
      #2;
      if (ram_ls) break;
      n++;
      tick();
    end
    chk("t6_idle_cycles", n, 17);
    drive_a(1, 1, 16'h0010, 32'h0, 4'h0);
    #1;
    chk("t6_wake", {ram_ls, a_if.cmd_ready, ram_cs}, 3'b100);
    tick();
    #2;
    chk("t6_grant", {ram_ls, a_if.cmd_ready, ram_cs}, 3'b011);
    tick();
    drive_a(0, 0, 0, 0, 0);
    #2;
    chk("t6_pend", {a_if.rsp_valid, a_if.rsp_rdata}, {1'b1, 32'hDEAD3344});
    rst_n = 1'b0;
    #1;
    chk("t6_rst", {a_if.rsp_valid, ram_ls, ram_cs}, 3'b000);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    #2;
    chk("t6_post", {a_if.rsp_valid, b_if.rsp_valid}, 2'b00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
